// File: rtl/axis_pack_pkg.sv
// Shared constants and helpers for the AXIS-to-native-FIFO packing bridges.
// Latency: n/a (elaboration-time constants and functions only).
// Backpressure: n/a.
package axis_pack_pkg;

    // Legal range of samples per packed FIFO word
    localparam int PACK_MIN = 1;
    localparam int PACK_MAX = 16;

    // Width of the count field: clog2 of the lane count, never below one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bit offset of the (nvalid-1) field inside a packed word
    function automatic int cnt_lsb(input int dw, input int pack);
        return dw * pack;
    endfunction

    // Bit offset of the last flag inside a packed word (the MSB)
    function automatic int last_bit(input int dw, input int pack);
        return dw * pack + clog2_min1(pack);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry output holding register feeding a native FIFO write port.
// Latency: word loaded at edge N is offered (wr) during cycle N+1.
// Backpressure: holds the word while full=1; free=1 when empty or draining this cycle.
module axis_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    input  logic         full,
    output logic [W-1:0] dout,
    output logic         wr,
    output logic         free
);

    logic out_valid;

    assign wr   = out_valid & ~full;
    assign free = ~out_valid | ~full;

    // Capture a new word when loaded; otherwise release the slot once it drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            dout      <= load_dat;
        end else if (wr) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis2nativefifo_pack.sv
// Packs PACK consecutive DW-bit AXIS samples into one {last, nvalid-1, lanes} FIFO word.
// Latency: completing beat accepted at edge N gives fifo_wr during cycle N+1 (FIFO not full).
// Backpressure: tready drops only while a finished word is held and fifo_full is high.
module axis2nativefifo_pack
    import axis_pack_pkg::*;
#(
    parameter int  DW   = 24,
    parameter int  PACK = 4,
    localparam int CW   = clog2_min1(PACK),
    localparam int FW   = PACK * DW + 1 + CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    input  logic          flush,
    output logic [FW-1:0] fifo_din,
    output logic          fifo_wr,
    input  logic          fifo_full,
    output logic [CW-1:0] lane_cnt
);

    localparam int            CNT_LSB   = cnt_lsb(DW, PACK);
    localparam int            LAST_BIT  = last_bit(DW, PACK);
    localparam logic [CW-1:0] LAST_LANE = CW'(PACK - 1);

    logic [DW-1:0] lanes [PACK];
    logic [CW-1:0] lane_idx;
    logic          flush_pend;
    logic          flush_act;
    logic          flush_evt;
    logic          free;
    logic          accept;
    logic          close;
    logic [CW-1:0] word_cnt;
    logic [FW-1:0] word;

    assign s_axis_tready = free;
    assign accept        = s_axis_tvalid & free;
    assign lane_cnt      = lane_idx;

    // A flush pulse acts in its own cycle and stays pending until it can close a word
    assign flush_act = flush_pend | flush;
    assign flush_evt = flush_act & ((lane_idx != '0) | accept) & free;
    assign close     = (accept & ((lane_idx == LAST_LANE) | s_axis_tlast)) | flush_evt;

    // Count field: index of the last filled lane, including a beat accepted now
    assign word_cnt = accept ? lane_idx : (lane_idx - CW'(1));

    // Assemble the closing word; lanes at or above the fill point read as zero
    always_comb begin
        word = '0;
        for (int i = 0; i < PACK; i++) begin
            if (CW'(i) < lane_idx) begin
                word[i*DW +: DW] = lanes[i];
            end else if (accept && (CW'(i) == lane_idx)) begin
                word[i*DW +: DW] = s_axis_tdata;
            end
        end
        word[CNT_LSB +: CW] = word_cnt;
        word[LAST_BIT]      = accept & s_axis_tlast;
    end

    // Lane storage, fill index and pending-flush tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_idx   <= '0;
            flush_pend <= 1'b0;
            for (int i = 0; i < PACK; i++) begin
                lanes[i] <= '0;
            end
        end else begin
            if (close) begin
                lane_idx <= '0;
            end else if (accept) begin
                lane_idx <= lane_idx + CW'(1);
            end
            if (accept) begin
                for (int i = 0; i < PACK; i++) begin
                    if (CW'(i) == lane_idx) begin
                        lanes[i] <= s_axis_tdata;
                    end
                end
            end
            // An empty register swallows the flush; a blocked partial word keeps it pending
            flush_pend <= flush_act & ~flush_evt & (lane_idx != '0);
        end
    end

    axis_out_reg #(
        .W (FW)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (close),
        .load_dat (word),
        .full     (fifo_full),
        .dout     (fifo_din),
        .wr       (fifo_wr),
        .free     (free)
    );

endmodule

// File: tb/tb_axis2nativefifo_pack.sv
module tb_axis2nativefifo_pack;

    localparam int DW   = 24;
    localparam int PACK = 4;
    localparam int CW   = 2;
    localparam int FW   = PACK * DW + 1 + CW;   // 99
    localparam int DW1  = 16;
    localparam int FW1  = DW1 + 1 + 1;          // 18

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic          flush = 1'b0;
    logic          full = 1'b0;

    logic          tready, fifo_wr;
    logic [FW-1:0] fifo_din;
    logic [CW-1:0] lane_cnt;

    logic           tready1, fifo_wr1;
    logic [FW1-1:0] fifo_din1;
    logic           lane_cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model state: samples gathered for the open word, held output word, pending flush
    logic [DW-1:0]  cur[$];
    logic           occ = 1'b0;
    logic [FW-1:0]  occ_w = '0;
    logic           fp = 1'b0;
    logic           occ1 = 1'b0;
    logic [FW1-1:0] occ_w1 = '0;

    always #5 clk = ~clk;

    axis2nativefifo_pack #(.DW(DW), .PACK(PACK)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .flush         (flush),
        .fifo_din      (fifo_din),
        .fifo_wr       (fifo_wr),
        .fifo_full     (full),
        .lane_cnt      (lane_cnt)
    );

    axis2nativefifo_pack #(.DW(DW1), .PACK(1)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (tdata[DW1-1:0]),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready1),
        .s_axis_tlast  (tlast),
        .flush         (flush),
        .fifo_din      (fifo_din1),
        .fifo_wr       (fifo_wr1),
        .fifo_full     (full),
        .lane_cnt      (lane_cnt1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check outputs 1 ns later, advance the model
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic fl, input logic fu);
        logic          fr, acc, fp_act, fr1;
        logic [FW-1:0] w;
        tvalid = v; tdata = d; tlast = l; flush = fl; full = fu;
        #1;
        fr = !occ || !fu;
        check("tready", tready, fr);
        check("fifo_wr", fifo_wr, occ && !fu);
        if (occ && !fu) begin
            check("fifo_din", fifo_din, occ_w);
            occ = 1'b0;
        end
        check("lane_cnt", lane_cnt, cur.size());
        acc    = v && fr;
        fp_act = fp || fl;
        if (acc) cur.push_back(d);
        if ((acc && (cur.size() == PACK || l)) || (fp_act && cur.size() > 0 && fr)) begin
            w = '0;
            foreach (cur[i]) w[i*DW +: DW] = cur[i];
            w[PACK*DW +: CW] = CW'(cur.size() - 1);
            w[FW-1]          = acc && l;
            occ   = 1'b1;
            occ_w = w;
            cur.delete();
            fp = 1'b0;
        end else begin
            fp = fp_act && (cur.size() > 0);
        end
        // Single-lane instance: every accepted beat is a word with a zero count field
        fr1 = !occ1 || !fu;
        check("tready1", tready1, fr1);
        check("fifo_wr1", fifo_wr1, occ1 && !fu);
        if (occ1 && !fu) begin
            check("fifo_din1", fifo_din1, occ_w1);
            occ1 = 1'b0;
        end
        if (v && fr1) begin
            occ1   = 1'b1;
            occ_w1 = {l, 1'b0, d[DW1-1:0]};
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic fu);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, fu);
    endtask

    // Asynchronous reset in mid-cycle: outputs must clear before any clock edge
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_wr", fifo_wr, 1'b0);
        check("rst_din", fifo_din, '0);
        check("rst_lane_cnt", lane_cnt, '0);
        check("rst_tready", tready, 1'b1);
        check("rst_wr1", fifo_wr1, 1'b0);
        check("rst_din1", fifo_din1, '0);
        cur.delete();
        occ = 1'b0; occ1 = 1'b0; fp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Eight consecutive samples fill two full words
        for (int k = 1; k <= 8; k++) step(1'b1, DW'(k), 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Three samples closed by tlast
        step(1'b1, 24'h000011, 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'h000012, 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'h000013, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);

        // FIFO full for five cycles while streaming
        for (int k = 0; k < 12; k++)
            step(1'b1, DW'(32'h20 + k), 1'b0, 1'b0, (k >= 2 && k < 7));
        idle(3, 1'b0);

        // Two samples then a flush pulse
        step(1'b1, 24'h000031, 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'h000032, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);

        // Flush with an empty pack register
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);

        // Flush coincident with a tlast beat, and flush coincident with a plain beat
        step(1'b1, 24'h000051, 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'h000052, 1'b1, 1'b1, 1'b0);
        step(1'b1, 24'h000053, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);

        // Flush while the FIFO is full: word held until full drops
        step(1'b1, 24'h000041, 1'b0, 1'b0, 1'b1);
        step(1'b1, 24'h000042, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1);
        idle(2, 1'b0);

        // Reset with two samples held
        step(1'b1, 24'h000061, 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'h000062, 1'b0, 1'b0, 1'b0);
        check("pre_rst_lane_cnt", lane_cnt, 2);
        do_reset();

        // Reset with an undelivered output word
        for (int k = 0; k < 4; k++) step(1'b1, DW'(32'h70 + k), 1'b0, 1'b0, 1'b1);
        do_reset();

        // Four samples after reset form a clean word
        for (int k = 0; k < 4; k++) step(1'b1, DW'(32'h80 + k), 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Randomised traffic
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        idle(4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
